// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 arbitrated output mux: arbitration mode
// codes and the select-width helper.
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Index width for n channels, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational arbiter: round-robin from a start pointer, or fixed priority
// (lowest index wins), using a doubled request vector so the wrap needs no special case.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int SEL_W   = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [SEL_W-1:0]  o_idx,
  output logic              o_any
);

  localparam int DW = 2 * NUM_CH;
  localparam int PW = $clog2(DW);

  logic [SEL_W-1:0] w_base;
  logic [DW-1:0]    w_masked;
  logic [PW-1:0]    w_pos;
  logic             w_hit;

  // Drop doubled-request bits below the start position, then take the lowest remaining bit.
  always_comb begin
    w_base   = (ARB_MODE == ARB_FIXED) ? '0 : i_ptr;
    w_masked = {i_req, i_req} & ({DW{1'b1}} << w_base);
    w_hit    = 1'b0;
    w_pos    = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      w_pos = w_masked[i] ? PW'(i) : w_pos;
      w_hit = w_hit | w_masked[i];
    end
  end

  // Fold the upper-copy position back onto a channel index and build the one-hot grant.
  always_comb begin
    o_any   = w_hit;
    o_idx   = SEL_W'((w_pos >= PW'(NUM_CH)) ? (w_pos - PW'(NUM_CH)) : w_pos);
    o_grant = w_hit ? (NUM_CH'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel arbitrated mux with valid/ready on every input and a one-deep
// registered output stage; the round-robin pointer advances only on accepted transfers.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int ARB_MODE = ARB_RR,
  localparam int SEL_W   = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] w_grant;
  logic [SEL_W-1:0]  w_idx;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic              w_any;
  logic              w_load_ok;
  logic              w_accept;
  logic [DATA_W-1:0] w_data;

  logic [SEL_W-1:0]  r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Handshake: rst_n gates in_ready so no channel sees an accept while reset is held.
  always_comb begin
    w_load_ok = ~r_out_valid | out_ready;
    w_accept  = w_any & w_load_ok & rst_n;
    in_ready  = w_grant & {NUM_CH{w_load_ok & rst_n}};
    w_ptr_nxt = (w_idx == SEL_W'(NUM_CH - 1)) ? '0 : (w_idx + SEL_W'(1));
  end

  // Select the granted channel's word.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_data = (w_idx == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : w_data;
    end
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_idx;
      r_ptr       <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
